alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 64, operand/result width; SHALL equal the shared ALU datapath width.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 reqN_valid  in  1  requester N (N=0,1) has an operation pending.
REQ-005 reqN_ready  out  1  requester N's operation accepted this cycle.
REQ-006 reqN_a, reqN_b  in  WIDTH  operands A and B.
REQ-007 reqN_op  in  3  ALU select S; reqN_cin  in  1  carry-in.
REQ-008 alu_abus, alu_bbus  out  WIDTH  registered operands driven to the ALU.
REQ-009 alu_s  out  3; alu_cin  out  1  registered select and carry-in to the ALU.
REQ-010 alu_out  in  WIDTH; alu_nzvc  in  4  ALU result and flags {N,Z,V,C}.
REQ-011 rsp_valid  out  1; rsp_ready  in  1  result handshake.
REQ-012 rsp_id  out  1; rsp_data  out  WIDTH; rsp_flags  out  4  originating requester, result, {N,Z,V,C}.

Function
REQ-013 FSM states: IDLE, EXEC, HOLD.
REQ-014 IDLE: if any reqN_valid, grant one requester, assert its reqN_ready combinationally, load its a/b/op/cin into ALU registers, go EXEC; else stay IDLE.
REQ-015 At most one reqN_ready SHALL be high in any cycle, and only in IDLE or in HOLD during a response handshake.
REQ-016 EXEC lasts exactly one cycle; at its end, capture alu_out, alu_nzvc and grant id into response registers, set rsp_valid, go HOLD.
REQ-017 Latency: rsp_valid SHALL rise on the second rising edge after the accepting edge.
REQ-018 HOLD: rsp_valid, rsp_id, rsp_data and rsp_flags SHALL stay stable while rsp_ready is 0.
REQ-019 HOLD with rsp_ready=1: clear rsp_valid; if any reqN_valid in the same cycle, grant and load it and go EXEC; else go IDLE.
REQ-020 Requesters SHALL hold valid and operands stable until ready; the arbiter never drops an accepted operation.
REQ-021 Opcodes (including S=3'b111) SHALL pass through unmodified; the arbiter does not decode them.
REQ-022 Outside a grant, ALU operand registers SHALL hold their last value.
REQ-023 Both requesters valid in the same cycle: the winner follows the arbitration policy in REQ-027/028.

Reset
REQ-024 Reset SHALL force state IDLE, rsp_valid=0, reqN_ready=0, and all ALU, response and pointer registers to 0 (pointer favours req0).
REQ-025 Reset asserted in EXEC or HOLD SHALL discard the in-flight operation; no response is produced for it.
REQ-026 On the first edge after reset deasserts, the block SHALL accept requests per REQ-014.

Configuration
REQ-027 With ALU_ARB_RR_EN defined: round-robin; on simultaneous requests, grant the requester not granted last, and update the pointer on every grant.
REQ-028 Without ALU_ARB_RR_EN: fixed priority; req0 always wins simultaneous requests; no pointer register.

Structure
REQ-029 Package alu_arb_pkg SHALL hold the FSM state typedef, flag index constants (N=3, Z=2, V=1, C=0) and ALU opcode constants (ADD=3'b010, SUB=3'b011, OR=3'b100, NOR=3'b101, AND=3'b110).
REQ-030 One sub-module, alu_arb_rr, SHALL implement the 2-way grant logic and the pointer, compiled per REQ-027/028.

Verification
REQ-031 req0: a=5, b=3, op=010, cin=0 -> rsp_valid two edges after accept, rsp_id=0, rsp_data=8, rsp_flags=4'b0000.
REQ-032 req1: a=3, b=3, op=011, cin=1 -> rsp_data=0, rsp_flags Z=1, C=1, N=0, V=0, rsp_id=1.
REQ-033 Both valid after reset, rsp_ready=1 -> order req0, req1, req0 with RR_EN; req0 only while held valid without RR_EN.
REQ-034 rsp_ready=0 for 5 cycles in HOLD with req1 valid -> response fields stable, req1_ready=0; req1 accepted on the handshake cycle.
REQ-035 reset pulsed during EXEC -> next cycle rsp_valid=0, all outputs 0, FSM IDLE, no response for the dropped operation.
REQ-036 Back-to-back: req0 held valid, rsp_ready=1 -> one new result every 2 cycles, no gap cycle in IDLE.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter: FSM state encoding,
// flag bit positions within {N,Z,V,C} and the ALU select codes.
package alu_arb_pkg;

    // FSM state type; plain logic constants keep the encoding visible in waves
    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE = 2'b00;
    localparam arb_state_t ST_EXEC = 2'b01;
    localparam arb_state_t ST_HOLD = 2'b10;

    // Bit positions of the ALU condition flags within a 4-bit {N,Z,V,C} word
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

    // ALU select codes; the arbiter forwards S untouched, these exist for users
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_NOR = 3'b101;
    localparam logic [2:0] OP_AND = 3'b110;

    // Index of the granted requester from a one-hot (or empty) grant vector
    function automatic logic grant_to_id(input logic [1:0] grant);
        return grant[1];
    endfunction

endpackage

// File: rtl/alu_arb_rr.sv
// Two-way grant logic for alu_arbiter.
// ALU_ARB_RR_EN defined  : round-robin, a tie goes to the requester not granted
//                          last; the pointer moves on every grant.
// ALU_ARB_RR_EN undefined: fixed priority, req[0] wins ties, no state at all.
module alu_arb_rr
    import alu_arb_pkg::*;
(
`ifdef ALU_ARB_RR_EN
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
`endif
    input  logic [1:0] req,
    output logic [1:0] grant,
    output logic       grant_id
);

`ifdef ALU_ARB_RR_EN
    // Requester favoured on the next tie; reset value favours req0
    logic prio;

    // Grant the lone requester, or the favoured one on a tie
    always_comb begin
        grant = 2'b00;
        if (req == 2'b11) begin
            grant = prio ? 2'b10 : 2'b01;
        end else begin
            grant = req;
        end
    end

    // Hand the tie preference to the other requester after every grant
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio <= 1'b0;
        end else if (en && (|req)) begin
            prio <= ~grant_to_id(grant);
        end
    end
`else
    // req0 always wins; req1 only when req0 is idle
    always_comb begin
        grant = 2'b00;
        if (req[0]) begin
            grant = 2'b01;
        end else if (req[1]) begin
            grant = 2'b10;
        end
    end
`endif

    assign grant_id = grant_to_id(grant);

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared combinational ALU.  The granted
// operation is registered onto the ALU buses, the ALU result is captured one
// cycle later and presented on a valid/ready response port tagged with the
// requester id.  A new grant can be taken on the response handshake cycle,
// giving one result every two cycles under continuous load.
// Optional: define ALU_ARB_RR_EN for round-robin arbitration (default: req0
// has fixed priority).
//
// state | meaning
// IDLE  | nothing in flight; grant any valid requester
// EXEC  | operands on ALU buses; capture result at end of cycle
// HOLD  | response valid; wait for rsp_ready, may grant on handshake
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    input  logic             req0_cin,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    input  logic             req1_cin,

    output logic [WIDTH-1:0] alu_abus,
    output logic [WIDTH-1:0] alu_bbus,
    output logic [2:0]       alu_s,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_out,
    input  logic [3:0]       alu_nzvc,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic [3:0]       rsp_flags
);

    arb_state_t state;
    logic       gnt_id_q;
    logic       accept_en;
    logic       take;
    logic [1:0] grant;
    logic       grant_id;

    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [2:0]       sel_op;
    logic             sel_cin;

    alu_arb_rr u_arb (
`ifdef ALU_ARB_RR_EN
        .clk      (clk),
        .reset    (reset),
        .en       (accept_en),
`endif
        .req      ({req1_valid, req0_valid}),
        .grant    (grant),
        .grant_id (grant_id)
    );

    // A grant is possible when idle, or when the held response is leaving
    always_comb begin
        accept_en = 1'b0;
        if (state == ST_IDLE) begin
            accept_en = 1'b1;
        end else if ((state == ST_HOLD) && rsp_ready) begin
            accept_en = 1'b1;
        end
    end

    assign take       = accept_en && (|grant);
    assign req0_ready = !reset && accept_en && grant[0];
    assign req1_ready = !reset && accept_en && grant[1];

    // Select the winning requester's operation for loading onto the ALU
    always_comb begin
        sel_a   = req0_a;
        sel_b   = req0_b;
        sel_op  = req0_op;
        sel_cin = req0_cin;
        if (grant_id) begin
            sel_a   = req1_a;
            sel_b   = req1_b;
            sel_op  = req1_op;
            sel_cin = req1_cin;
        end
    end

    // Sequencing: one EXEC cycle per grant, HOLD until the response is taken
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (take) begin
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (rsp_ready) begin
                        state <= take ? ST_EXEC : ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // ALU operand registers load only on a grant and otherwise keep their value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_abus <= '0;
            alu_bbus <= '0;
            alu_s    <= 3'b000;
            alu_cin  <= 1'b0;
            gnt_id_q <= 1'b0;
        end else if (take) begin
            alu_abus <= sel_a;
            alu_bbus <= sel_b;
            alu_s    <= sel_op;
            alu_cin  <= sel_cin;
            gnt_id_q <= grant_id;
        end
    end

    // Capture the ALU result at the end of EXEC; drop valid on the handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_flags <= 4'b0000;
        end else if (state == ST_EXEC) begin
            rsp_valid         <= 1'b1;
            rsp_id            <= gnt_id_q;
            rsp_data          <= alu_out;
            rsp_flags[FLAG_N] <= alu_nzvc[FLAG_N];
            rsp_flags[FLAG_Z] <= alu_nzvc[FLAG_Z];
            rsp_flags[FLAG_V] <= alu_nzvc[FLAG_V];
            rsp_flags[FLAG_C] <= alu_nzvc[FLAG_C];
        end else if ((state == ST_HOLD) && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a behavioural ALU and a
// transaction-level reference model (expected-response queue, latency queue,
// arbitration winner).  Honours ALU_ARB_RR_EN for the arbitration policy.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    localparam int W = 64;

    logic         clk;
    logic         reset;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]   req0_op, req1_op;
    logic         req0_cin, req1_cin;
    logic [W-1:0] alu_abus, alu_bbus, alu_out;
    logic [2:0]   alu_s;
    logic         alu_cin;
    logic [3:0]   alu_nzvc;
    logic         rsp_valid, rsp_ready, rsp_id;
    logic [W-1:0] rsp_data;
    logic [3:0]   rsp_flags;

    int n_cmp = 0;
    int n_err = 0;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
        .req0_b(req0_b), .req0_op(req0_op), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
        .req1_b(req1_b), .req1_op(req1_op), .req1_cin(req1_cin),
        .alu_abus(alu_abus), .alu_bbus(alu_bbus), .alu_s(alu_s), .alu_cin(alu_cin),
        .alu_out(alu_out), .alu_nzvc(alu_nzvc),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference ALU: returns {N,Z,V,C, result}
    function automatic logic [W+3:0] alu_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic [2:0] op, input logic cin);
        logic [W:0]   s;
        logic [W-1:0] r;
        logic         v, c;
        v = 1'b0;
        c = 1'b0;
        case (op)
            OP_ADD: begin
                s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
                r = s[W-1:0];
                c = s[W];
                v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            OP_SUB: begin
                s = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, cin};
                r = s[W-1:0];
                c = s[W];
                v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            OP_OR:   r = a | b;
            OP_NOR:  r = ~(a | b);
            OP_AND:  r = a & b;
            default: r = a ^ b;
        endcase
        return {r[W-1], (r == '0), v, c, r};
    endfunction

    // Environment ALU driven by the arbiter's registered buses
    always_comb {alu_nzvc, alu_out} = alu_model(alu_abus, alu_bbus, alu_s, alu_cin);

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model and per-cycle compare ----------------
    logic [W+4:0] exp_q[$];   // {id, flags, data}
    int           lat_q[$];   // cycle index of each accept
    int           cyc = 0;
    logic         rr_last = 1'b1;
    logic         prev_valid = 1'b0;
    logic         prev_stall = 1'b0;
    logic [69:0]  prev_rsp;
    logic         exec_now, can_accept;
    logic [1:0]   exp_grant;
    logic [W+4:0] e;
    logic         win_id;

    always @(negedge clk or posedge reset) begin
        if (reset) begin
            exp_q.delete();
            lat_q.delete();
            rr_last    = 1'b1;
            prev_valid = 1'b0;
            prev_stall = 1'b0;
        end else begin
            cyc++;
            if (rsp_valid && !prev_valid) begin
                if (lat_q.size() == 0) chk("spurious_valid", 1, 0);
                else chk("latency", cyc - lat_q.pop_front(), 2);
            end
            exec_now   = (lat_q.size() != 0);
            can_accept = !exec_now && (!rsp_valid || rsp_ready);
            chk("one_ready", {req1_ready, req0_ready} == 2'b11, 0);
            if (!can_accept) begin
                chk("ready_blocked", {req1_ready, req0_ready}, 2'b00);
            end else begin
                exp_grant = 2'b00;
                if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_RR_EN
                    exp_grant = (rr_last == 1'b0) ? 2'b10 : 2'b01;
`else
                    exp_grant = 2'b01;
`endif
                end else if (req0_valid) exp_grant = 2'b01;
                else if (req1_valid) exp_grant = 2'b10;
                chk("ready_grant", {req1_ready, req0_ready}, exp_grant);
            end
            if (prev_stall) chk("hold_stable", {rsp_valid, rsp_id, rsp_data, rsp_flags}, prev_rsp);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_id", rsp_id, e[W+4]);
                    chk("rsp_flags", rsp_flags, e[W+3:W]);
                    chk("rsp_data", rsp_data, e[W-1:0]);
                end
            end
            if (req0_ready || req1_ready) begin
                win_id = req1_ready;
                if (win_id) exp_q.push_back({1'b1, alu_model(req1_a, req1_b, req1_op, req1_cin)});
                else        exp_q.push_back({1'b0, alu_model(req0_a, req0_b, req0_op, req0_cin)});
                lat_q.push_back(cyc);
                rr_last = win_id;
            end
            prev_stall = rsp_valid && !rsp_ready;
            prev_rsp   = {rsp_valid, rsp_id, rsp_data, rsp_flags};
            prev_valid = rsp_valid;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic send(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] op, input logic cin);
        logic got;
        if (id) begin
            req1_a = a; req1_b = b; req1_op = op; req1_cin = cin; req1_valid = 1'b1;
        end else begin
            req0_a = a; req0_b = b; req0_op = op; req0_cin = cin; req0_valid = 1'b1;
        end
        got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            got = id ? req1_ready : req0_ready;
        end
        chk("accept_timeout", got, 1);
        @(posedge clk); #1;
        if (id) req1_valid = 1'b0;
        else    req0_valid = 1'b0;
    endtask

    logic       gids[3];
    int         gcyc[3];
    logic [2:0] exp_order;
    int         ng;

    initial begin
        reset = 1'b1;
        req0_valid = 0; req1_valid = 0;
        req0_a = '0; req0_b = '0; req0_op = '0; req0_cin = 0;
        req1_a = '0; req1_b = '0; req1_op = '0; req1_cin = 0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_outputs", {alu_abus, alu_bbus, alu_s, alu_cin, rsp_id, rsp_flags}, 0);
        chk("rst_rsp_data", rsp_data, 0);
        reset = 1'b0;

        // ADD 5+3
        send(1'b0, 64'd5, 64'd3, OP_ADD, 1'b0);
        @(negedge clk); chk("add_exec_valid", rsp_valid, 0);
        @(negedge clk);
        chk("add_valid", rsp_valid, 1);
        chk("add_id", rsp_id, 0);
        chk("add_data", rsp_data, 8);
        chk("add_flags", rsp_flags, 4'b0000);
        @(posedge clk); #1;

        // SUB 3-3 with carry-in
        send(1'b1, 64'd3, 64'd3, OP_SUB, 1'b1);
        @(negedge clk); @(negedge clk);
        chk("sub_valid", rsp_valid, 1);
        chk("sub_id", rsp_id, 1);
        chk("sub_data", rsp_data, 0);
        chk("sub_flags", rsp_flags, 4'b0101);
        @(posedge clk); #1;

        // Undecoded select passes through
        send(1'b0, 64'h1234, 64'h00ff, 3'b111, 1'b1);
        @(negedge clk);
        chk("op7_s", alu_s, 3'b111);
        chk("op7_cin", alu_cin, 1);
        chk("op7_abus", alu_abus, 64'h1234);
        chk("op7_bbus", alu_bbus, 64'h00ff);
        @(negedge clk);
        chk("op7_data", rsp_data, 64'h12cb);
        @(posedge clk); #1;

        // Response stall with req1 waiting
        rsp_ready = 1'b0;
        send(1'b0, 64'd100, 64'd23, OP_AND, 1'b0);
        @(negedge clk); @(negedge clk);
        chk("stall_valid", rsp_valid, 1);
        chk("stall_data", rsp_data, 4);
        @(posedge clk); #1;
        req1_a = 64'd3; req1_b = 64'd4; req1_op = OP_OR; req1_cin = 0; req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_req1_ready", req1_ready, 0);
            chk("stall_hold", {rsp_valid, rsp_id, rsp_data}, {1'b1, 1'b0, 64'd4});
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk); chk("hs_req1_ready", req1_ready, 1);
        @(posedge clk); #1; req1_valid = 1'b0;
        @(negedge clk); chk("hs_exec_valid", rsp_valid, 0);
        @(negedge clk);
        chk("or_valid", rsp_valid, 1);
        chk("or_id", rsp_id, 1);
        chk("or_data", rsp_data, 7);
        @(posedge clk); #1;

        // Reset during EXEC drops the operation
        send(1'b0, 64'd9, 64'd9, OP_ADD, 1'b0);
        reset = 1'b1;
        #1;
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_outputs", {alu_abus, alu_bbus, alu_s, alu_cin, rsp_id, rsp_flags, req0_ready, req1_ready}, 0);
        chk("midrst_rsp_data", rsp_data, 0);
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_no_rsp", rsp_valid, 0);
        end
        @(posedge clk); #1;

        // Both requesters held valid, back-to-back
        req0_a = 64'd10; req0_b = 64'd1; req0_op = OP_SUB; req0_cin = 1'b1; req0_valid = 1'b1;
        req1_a = 64'd7;  req1_b = 64'd8; req1_op = OP_ADD; req1_cin = 1'b0; req1_valid = 1'b1;
        ng = 0;
        for (int n = 0; n < 40 && ng < 3; n++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                gids[ng] = req1_ready;
                gcyc[ng] = n;
                ng++;
            end
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("both_grants", ng, 3);
`ifdef ALU_ARB_RR_EN
        exp_order = 3'b010;
`else
        exp_order = 3'b000;
`endif
        if (ng == 3) begin
            chk("order0", gids[0], exp_order[2]);
            chk("order1", gids[1], exp_order[1]);
            chk("order2", gids[2], exp_order[0]);
            chk("b2b_gap1", gcyc[1] - gcyc[0], 2);
            chk("b2b_gap2", gcyc[2] - gcyc[1], 2);
        end
        repeat (5) @(negedge clk);
        chk("drain", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
